// File: rtl/an_an_co_pkg.sv
// Shared constants and helpers for the an_an_co runtime monitor
// (rule: a |-> ##1 b[*0:2] ##1 c).
package an_an_co_pkg;

  localparam int MAX_REP = 2;
  localparam int DEPTH   = MAX_REP + 1;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/an_an_co_sat_cnt.sv
// Saturating event accumulator: adds a 0..3 increment per edge and clamps at all-ones.
module an_an_co_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   sum_s;

  // Next count: widened sum with carry-out forcing saturation
  always_comb begin
    sum_s = {1'b0, count_q} + {{(W-1){1'b0}}, inc};
    if (sum_s[W]) begin
      count_d = {W{1'b1}};
    end else begin
      count_d = sum_s[W-1:0];
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/an_an_co.sv
// Hardware checker for "a |-> ##1 b[*0:2] ##1 c": one stage bit per attempt age,
// registered per-edge verdicts, saturating pass/fail totals and a sticky error flag.
module an_an_co
  import an_an_co_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       pass_num,
  output logic [1:0]       fail_num,
  output logic             busy,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_sticky
);

  // stage_q[k] : an attempt opened k+1 edges ago is still alive
  logic [DEPTH-1:0] stage_q, stage_d;
  logic [DEPTH-1:0] pass_vec_s, fail_vec_s;
  logic             pass_q, pass_d, fail_q, fail_d;
  logic [1:0]       pass_num_q, pass_num_d, fail_num_q, fail_num_d;
  logic             busy_q, busy_d, err_q, err_d;

  // Verdicts from the current stages; c outranks b, the oldest stage fails on ~c alone
  always_comb begin
    pass_vec_s = stage_q & {DEPTH{c}};
    fail_vec_s = {stage_q[DEPTH-1] & ~c,
                  stage_q[DEPTH-2:0] & {(DEPTH-1){~c & ~b}}};
    stage_d    = {stage_q[DEPTH-2:0] & {(DEPTH-1){~c & b}}, a};
    pass_num_d = popcount3(pass_vec_s);
    fail_num_d = popcount3(fail_vec_s);
    pass_d     = |pass_vec_s;
    fail_d     = |fail_vec_s;
    busy_d     = |stage_d;
    err_d      = err_q | fail_d;
  end

  // Stage and verdict registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q    <= {DEPTH{1'b0}};
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_num_q <= 2'd0;
      fail_num_q <= 2'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_num_q <= pass_num_d;
      fail_num_q <= fail_num_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Totals advance on the same edge that registers the verdict
  an_an_co_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pass_num_d),
    .count (pass_count)
  );

  an_an_co_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_num_d),
    .count (fail_count)
  );

  assign pass       = pass_q;
  assign fail       = fail_q;
  assign pass_num   = pass_num_q;
  assign fail_num   = fail_num_q;
  assign busy       = busy_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_an_an_co.sv
// Directed bench for an_an_co: default 16-bit counters plus a 2-bit-counter
// instance sharing the same stimulus for the saturation scenario.
module tb_an_an_co;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0;
  logic        pass, fail, busy, err_sticky;
  logic [1:0]  pass_num, fail_num;
  logic [15:0] pass_count, fail_count;
  logic        pass2, fail2, busy2, err2;
  logic [1:0]  pass_num2, fail_num2;
  logic [1:0]  pass_count2, fail_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  an_an_co #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .pass(pass), .fail(fail), .pass_num(pass_num), .fail_num(fail_num),
    .busy(busy), .pass_count(pass_count), .fail_count(fail_count),
    .err_sticky(err_sticky)
  );

  an_an_co #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .pass(pass2), .fail(fail2), .pass_num(pass_num2), .fail_num(fail_num2),
    .busy(busy2), .pass_count(pass_count2), .fail_count(fail_count2),
    .err_sticky(err2)
  );

  // drive inputs on negedge, then sample 1 time unit after the next posedge
  task automatic step(input logic ia, input logic ib, input logic ic);
    @(negedge clk);
    a = ia; b = ib; c = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({pass, fail, pass_num, fail_num, busy, err_sticky} !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0", {pass, fail, pass_num, fail_num, busy, err_sticky});
    end
    checks++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", pass_count, fail_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overlap_pass();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL t1_e1: busy=%b pass=%b expected busy=1 pass=0", busy, pass);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL t1_e2: pass=%b fail=%b expected 0 0", pass, fail);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (pass_num !== 2'd2 || pass !== 1'b1) begin
      errors++;
      $display("FAIL t1_pass_num: got %0d (pass=%b) expected 2 (pass=1)", pass_num, pass);
    end
    checks++;
    if (fail !== 1'b0 || pass_count !== 16'd2) begin
      errors++;
      $display("FAIL t1_count: fail=%b pass_count=%0d expected fail=0 pass_count=2", fail, pass_count);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || pass !== 1'b0 || pass_count !== 16'd2) begin
      errors++;
      $display("FAIL t1_e4: busy=%b pass=%b pass_count=%0d expected 0 0 2", busy, pass, pass_count);
    end
  endtask

  task automatic test_stall_fail();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (fail !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL t2_e1: fail=%b err=%b expected 0 0", fail, err_sticky);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (fail_num !== 2'd1 || fail !== 1'b1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL t2_e2: fail_num=%0d fail=%b err=%b expected 1 1 1", fail_num, fail, err_sticky);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (fail_num !== 2'd1 || fail_count !== 16'd2) begin
      errors++;
      $display("FAIL t2_e3: fail_num=%0d fail_count=%0d expected 1 2", fail_num, fail_count);
    end
    checks++;
    if (err_sticky !== 1'b1 || busy !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL t2_state: err=%b busy=%b pass=%b expected 1 0 0", err_sticky, busy, pass);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (fail !== 1'b0 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL t2_sticky: fail=%b err=%b expected 0 1", fail, err_sticky);
    end
  endtask

  task automatic test_max_repeat();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_e2: pass=%b fail=%b busy=%b expected 0 0 1", pass, fail, busy);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_e3: pass=%b fail=%b busy=%b expected 0 0 1", pass, fail, busy);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (pass_num !== 2'd1 || fail !== 1'b0 || pass_count !== 16'd3) begin
      errors++;
      $display("FAIL t3_e4: pass_num=%0d fail=%b pass_count=%0d expected 1 0 3", pass_num, fail, pass_count);
    end
    checks++;
    if (busy !== 1'b0 || fail_count !== 16'd2) begin
      errors++;
      $display("FAIL t3_tail: busy=%b fail_count=%0d expected 0 2", busy, fail_count);
    end
  endtask

  task automatic test_too_many_b();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (fail !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL t4_early: fail=%b pass=%b expected 0 0", fail, pass);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (fail_num !== 2'd1 || pass !== 1'b0 || fail_count !== 16'd3) begin
      errors++;
      $display("FAIL t4_e4: fail_num=%0d pass=%b fail_count=%0d expected 1 0 3", fail_num, pass, fail_count);
    end
    checks++;
    if (busy !== 1'b0 || pass_count !== 16'd3) begin
      errors++;
      $display("FAIL t4_tail: busy=%b pass_count=%0d expected 0 3", busy, pass_count);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t5_busy_before: got %b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pass, fail, pass_num, fail_num, busy, err_sticky} !== 8'd0) begin
      errors++;
      $display("FAIL t5_async_flags: got %b expected 0", {pass, fail, pass_num, fail_num, busy, err_sticky});
    end
    checks++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0) begin
      errors++;
      $display("FAIL t5_async_counts: got %0d/%0d expected 0/0", pass_count, fail_count);
    end
    @(negedge clk);
    a = 1'b0; b = 1'b1; c = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_discard: pass=%b fail=%b busy=%b expected 0 0 0", pass, fail, busy);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL t5_after: counts %0d/%0d err=%b expected 0/0 0", pass_count, fail_count, err_sticky);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (pass_num2 !== 2'd1 || pass_num !== 2'd1) begin
        errors++;
        $display("FAIL t6_pass_%0d: pass_num=%0d/%0d expected 1/1", i, pass_num, pass_num2);
      end
    end
    checks++;
    if (pass_count2 !== 2'd3) begin
      errors++;
      $display("FAIL t6_sat: pass_count=%0d expected 3", pass_count2);
    end
    checks++;
    if (pass_count !== 16'd5 || fail_count2 !== 2'd0) begin
      errors++;
      $display("FAIL t6_wide: pass_count=%0d fail_count2=%0d expected 5 0", pass_count, fail_count2);
    end
  endtask

  initial begin
    test_reset();
    test_overlap_pass();
    test_stall_fail();
    test_max_repeat();
    test_too_many_b();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
